alu_exec: RTL

- Execute-stage ALU that consumes the 4-bit ALU control code from the ALU controller, plus two 32-bit operands.
- Single-cycle ops (and/or/add/sub/slt/nor) complete in one registered cycle. The new MUL code runs a 32-iteration shift-add multiplier.
- Valid/ready handshakes on input and output so the pipeline can stall on multi-cycle ops.
- Sits between ALU_Ctrl/operand mux and the EX/MEM register.

---
 rtl/alu_pkg.sv | 15 +
 rtl/mul_iter.sv | 50 +++++
 rtl/alu_exec.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALU control codes and execute-stage FSM states shared across the EX stage
`timescale 1ns/1ps
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

endpackage

// File: rtl/mul_iter.sv
// mul_iter: WIDTH-iteration shift-add multiplier keeping the low WIDTH bits of the product
`timescale 1ns/1ps
module mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;

    // product is the accumulator after this edge's iteration, so the final value is usable on the done edge
    assign product = mplier[0] ? acc + mcand : acc;
    assign done    = busy && cnt == CW'(WIDTH - 1);

    // load operands on start, then one shift-add step per cycle until the last iteration
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            busy   <= !done;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execute-stage ALU with valid/ready handshakes and a multi-cycle multiply
`timescale 1ns/1ps
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o
);

    state_t           state;
    logic             accept;
    logic             is_mul;
    logic             mul_busy;
    logic             mul_done;
    logic             lt;
    logic             ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_product;

    // DONE passes consumer readiness straight through so a new op can enter as the result leaves
    assign ready_o = !mul_busy && (state == IDLE || (state == DONE && ready_i));
    assign accept  = valid_i && ready_o;
    assign is_mul  = ALUCtrl_i == ALU_MUL;

    mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start   (accept && is_mul),
        .a       (src1_i),
        .b       (src2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // single-cycle datapath; slt uses a true signed compare so it stays right when a-b overflows
    always_comb begin
        sum     = src1_i + src2_i;
        diff    = src1_i - src2_i;
        lt      = $signed(src1_i) < $signed(src2_i);
        alu_res = ALUCtrl_i == ALU_AND ? src1_i & src2_i :
                  ALUCtrl_i == ALU_OR  ? src1_i | src2_i :
                  ALUCtrl_i == ALU_ADD ? sum :
                  ALUCtrl_i == ALU_SUB ? diff :
                  ALUCtrl_i == ALU_SLT ? WIDTH'(lt) :
                  ALUCtrl_i == ALU_NOR ? ~(src1_i | src2_i) : '0;
        ovf     = ALUCtrl_i == ALU_ADD ? src1_i[WIDTH-1] == src2_i[WIDTH-1] && sum[WIDTH-1] != src1_i[WIDTH-1] :
                  ALUCtrl_i == ALU_SUB ? src1_i[WIDTH-1] != src2_i[WIDTH-1] && diff[WIDTH-1] != src1_i[WIDTH-1] :
                  1'b0;
    end

    // handshake FSM with registered result/flags; outputs only change on accept or multiply completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            valid_o    <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else if (state == MUL) begin
            if (mul_done) begin
                state      <= DONE;
                valid_o    <= 1'b1;
                result_o   <= mul_product;
                zero_o     <= mul_product == '0;
                overflow_o <= 1'b0;
            end
        end else if (accept) begin
            if (is_mul) begin
                state   <= MUL;
                valid_o <= 1'b0;
            end else begin
                state      <= DONE;
                valid_o    <= 1'b1;
                result_o   <= alu_res;
                zero_o     <= alu_res == '0;
                overflow_o <= ovf;
            end
        end else if (state == DONE && ready_i) begin
            state   <= IDLE;
            valid_o <= 1'b0;
        end
    end

endmodule
